hilo_muldiv_ctrl: RTL

- Execute-stage sequencer placed directly around the 32-cycle shift-add unsigned multiplier core (start/busy/a/b/h/l interface).
- Decodes MULT, MULTU, MTHI and MTLO requests and launches the core.
- Applies sign correction for MULT, stalls the pipeline while the core is busy, and owns the architectural HI/LO registers. MFHI/MFLO read the hi and lo outputs directly.

---
 rtl/hilo_muldiv_ctrl_if.sv | 29 ++
 rtl/hilo_muldiv_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage HI/LO bundle: pipeline operands and stall on one side,
// the shift-add multiplier core handshake on the other.
interface hilo_muldiv_ctrl_if #(
    parameter int W = 32
);
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         mul_start;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic         mul_busy;
    logic [W-1:0] mul_h;
    logic [W-1:0] mul_l;

    modport slave (
        input  op_valid, op, rs_data, rt_data, mul_busy, mul_h, mul_l,
        output stall, hi, lo, mul_start, mul_a, mul_b
    );

    modport master (
        output op_valid, op, rs_data, rt_data, mul_busy, mul_h, mul_l,
        input  stall, hi, lo, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer around a 32-cycle unsigned multiplier core: launches the
// core, stalls the pipe while it runs, sign-corrects MULT and owns HI/LO.
module hilo_muldiv_ctrl #(
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               reset,
    hilo_muldiv_ctrl_if.slave  bus
);
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MULT  = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           neg_q, neg_d;
    logic           start_q, start_d;
    logic           stall_c;

    logic           is_mul;
    logic [W-1:0]   rs_mag, rt_mag;
    logic [2*W-1:0] prod, prod_fix;

    assign is_mul = bus.op_valid && (bus.op == OP_MULTU || bus.op == OP_MULT);

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude for the core.
    assign rs_mag = bus.rs_data[W-1] ? (~bus.rs_data + W'(1)) : bus.rs_data;
    assign rt_mag = bus.rt_data[W-1] ? (~bus.rt_data + W'(1)) : bus.rt_data;

    assign prod     = {bus.mul_h, bus.mul_l};
    assign prod_fix = neg_q ? (~prod + (2*W)'(1)) : prod;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (is_mul) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (!bus.mul_busy) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        start_d = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.rs_data;
                        OP_MTLO: lo_d = bus.rs_data;
                        OP_MULTU: begin
                            a_d     = bus.rs_data;
                            b_d     = bus.rt_data;
                            neg_d   = 1'b0;
                            start_d = 1'b1;
                            stall_c = 1'b1;
                        end
                        OP_MULT: begin
                            a_d     = rs_mag;
                            b_d     = rt_mag;
                            neg_d   = bus.rs_data[W-1] ^ bus.rt_data[W-1];
                            start_d = 1'b1;
                            stall_c = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_LAUNCH: stall_c = 1'b1;
            S_WAIT: begin
                stall_c = 1'b1;
                if (!bus.mul_busy) {hi_d, lo_d} = prod_fix;
            end
            // DONE lets the multiply retire; the op still on the bus is the
            // same instruction, so it is deliberately ignored.
            S_DONE:   stall_c = 1'b0;
            default:  stall_c = 1'b0;
        endcase
        if (!reset) stall_c = 1'b0;
    end

    assign bus.stall     = stall_c;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.mul_start = start_q;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
endmodule
